// File: rtl/lsu_core.sv
// lsu_core: load/store unit sitting in front of the data memory.
// Takes one request at a time, turns it into an aligned 64-bit access with
// a byte-lane mask and lane-shifted store data, waits LATENCY cycles, then
// returns extended load data (or a misalignment flag) on the response channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_addr, req_wdata   byte address, right-aligned store data
//   req_wen               1 = store, 0 = load
//   req_size              0 byte, 1 half, 2 word, 3 dword
//   req_unsigned          zero-extend loads when 1
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data (0 for stores/misaligned)
//   resp_misalign         request was misaligned, memory untouched
//   mem_raddr, mem_waddr  aligned address to memory
//   mem_wdata, mem_wmask  lane-shifted store data and byte mask
//   mem_wen               one-cycle write strobe
//   mem_rdata             combinational read data from memory
module lsu_core #(
  parameter int unsigned LATENCY    = 1,
  parameter logic [63:0] RESET_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        wen_q;
  logic        uns_q;

  logic        accept;
  logic        last_cycle;
  logic        misalign_in;
  logic [7:0]  lane_mask;
  logic [63:0] rd_shift;
  logic [63:0] load_val;

  assign accept     = req_valid && (state == IDLE);
  assign last_cycle = (state == BUSY) && (cnt == 4'd0);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_raddr  = addr_q;
  assign mem_waddr  = addr_q;
  assign mem_wen    = last_cycle && wen_q;
  assign mem_wmask  = mem_wen ? lane_mask : 8'h00;
  // Bits shifted past lane 7 are intentionally dropped.
  assign mem_wdata  = wdata_q << {off_q, 3'b000};

  // Misaligned when the address is not a multiple of the access size.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    misalign_in = 1'b0;
    case (req_size)
      2'd0: misalign_in = 1'b0;
      2'd1: misalign_in = req_addr[0];
      2'd2: misalign_in = |req_addr[1:0];
      2'd3: misalign_in = |req_addr[2:0];
      default: misalign_in = 1'b0;
    endcase
  end

  always_comb begin
    lane_mask = 8'h00;
    case (size_q)
      2'd0: lane_mask = 8'h01 << off_q;
      2'd1: lane_mask = 8'h03 << off_q;
      2'd2: lane_mask = 8'h0F << off_q;
      2'd3: lane_mask = 8'hFF;
      default: lane_mask = 8'h00;
    endcase
  end

  // Move the addressed field down to bit 0, then extend from its top bit.
  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = rd_shift;
    case (size_q)
      2'd0: load_val = uns_q ? {56'd0, rd_shift[7:0]}
                             : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: load_val = uns_q ? {48'd0, rd_shift[15:0]}
                             : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: load_val = uns_q ? {32'd0, rd_shift[31:0]}
                             : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = misalign_in ? RESP : BUSY;
      BUSY: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every datapath register is reset, because the reset values are
  // visible on the memory and response ports and an aborted store must not leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 4'd0;
      addr_q        <= RESET_ADDR;
      wdata_q       <= 64'd0;
      off_q         <= 3'd0;
      size_q        <= 2'd0;
      wen_q         <= 1'b0;
      uns_q         <= 1'b0;
      resp_rdata    <= 64'd0;
      resp_misalign <= 1'b0;
    end else begin
      if (accept) begin
        wdata_q <= req_wdata;
        off_q   <= req_addr[2:0];
        size_q  <= req_size;
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        if (misalign_in) begin
          resp_misalign <= 1'b1;
          resp_rdata    <= 64'd0;
        end else begin
          addr_q <= {req_addr[63:3], 3'b000};
          cnt    <= CNT_INIT;
        end
      end

      if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;

      if (last_cycle) resp_rdata <= wen_q ? 64'd0 : load_val;

      if (state == RESP && resp_ready) resp_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_core.sv
// Testbench for lsu_core: two instances (LATENCY=1 and LATENCY=4) share a
// small memory model. Expected responses are queued when a request is
// driven and compared when the response handshake completes.
module tb_lsu_core;

  localparam logic [63:0] RESET_ADDR = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [63:0] rdata;
    logic        misalign;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] waddr;
  } exp_t;

  logic        clk;
  logic        rst_n         [2];
  logic        req_valid     [2];
  logic        req_ready     [2];
  logic [63:0] req_addr      [2];
  logic [63:0] req_wdata     [2];
  logic        req_wen       [2];
  logic [1:0]  req_size      [2];
  logic        req_unsigned  [2];
  logic        resp_valid    [2];
  logic        resp_ready    [2];
  logic [63:0] resp_rdata    [2];
  logic        resp_misalign [2];
  logic [63:0] mem_raddr     [2];
  logic [63:0] mem_waddr     [2];
  logic [63:0] mem_wdata     [2];
  logic [7:0]  mem_wmask     [2];
  logic        mem_wen       [2];
  logic [63:0] mem_rdata     [2];

  logic [63:0] mem [16];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;

  assign mem_rdata[0] = mem[mem_raddr[0][6:3]];
  assign mem_rdata[1] = mem[mem_raddr[1][6:3]];

  lsu_core #(.LATENCY(1), .RESET_ADDR(RESET_ADDR)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_wen(req_wen[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_misalign(resp_misalign[0]), .mem_raddr(mem_raddr[0]),
    .mem_waddr(mem_waddr[0]), .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]),
    .mem_wen(mem_wen[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_core #(.LATENCY(4), .RESET_ADDR(RESET_ADDR)) u_lat4 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_wen(req_wen[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_misalign(resp_misalign[1]), .mem_raddr(mem_raddr[1]),
    .mem_waddr(mem_waddr[1]), .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]),
    .mem_wen(mem_wen[1]), .mem_rdata(mem_rdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, " req_ready"},     64'(req_ready[d]),     64'd1);
    check({tag, " resp_valid"},    64'(resp_valid[d]),    64'd0);
    check({tag, " resp_rdata"},    resp_rdata[d],         64'd0);
    check({tag, " resp_misalign"}, 64'(resp_misalign[d]), 64'd0);
    check({tag, " mem_raddr"},     mem_raddr[d],          RESET_ADDR);
    check({tag, " mem_waddr"},     mem_waddr[d],          RESET_ADDR);
    check({tag, " mem_wdata"},     mem_wdata[d],          64'd0);
    check({tag, " mem_wmask"},     64'(mem_wmask[d]),     64'd0);
    check({tag, " mem_wen"},       64'(mem_wen[d]),       64'd0);
  endtask

  // One full transaction: compute the expected outcome from the memory model,
  // drive the request, watch the memory port, then hold and complete the response.
  task automatic do_access(input int d, input string tag, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic wen,
                           input logic [1:0] size, input logic uns, input int hold);
    exp_t        e, got;
    int          o, nb, lat, pulses, k;
    bit          seen;
    logic [63:0] word, raddr0, held;

    o   = int'(addr[2:0]);
    nb  = 1 << size;
    lat = (d == 0) ? 1 : 4;
    e.misalign = (addr % (64'd1 << size)) != 64'd0;
    e.rdata    = 64'd0;
    e.wmask    = 8'h00;
    e.waddr    = {addr[63:3], 3'b000};
    e.wdata    = wdata << (8 * o);
    if (!e.misalign && !wen) begin
      word = mem[addr[6:3]];
      for (int i = 0; i < nb; i++) e.rdata[8*i +: 8] = word[8*(o+i) +: 8];
      if (!uns && size != 2'd3 && e.rdata[8*nb-1])
        for (int i = nb; i < 8; i++) e.rdata[8*i +: 8] = 8'hFF;
    end
    if (!e.misalign && wen)
      for (int i = 0; i < 8; i++) e.wmask[i] = (i >= o) && (i < o + nb);
    sb.push_back(e);
    raddr0 = mem_raddr[d];

    @(negedge clk);
    check({tag, " req_ready idle"}, 64'(req_ready[d]), 64'd1);
    req_addr[d] = addr; req_wdata[d] = wdata; req_wen[d] = wen;
    req_size[d] = size; req_unsigned[d] = uns; req_valid[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    // Scribble on the inputs: they must be ignored outside IDLE.
    req_addr[d] = 64'hFFFF_FFFF_FFFF_FFFF; req_wdata[d] = 64'h5A5A_5A5A_5A5A_5A5A;

    pulses = 0;
    seen   = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_wen[d]) begin
        pulses++;
        check({tag, " mem_waddr"}, mem_waddr[d], e.waddr);
        check({tag, " mem_wmask"}, 64'(mem_wmask[d]), 64'(e.wmask));
        check({tag, " mem_wdata"}, mem_wdata[d], e.wdata);
        for (int i = 0; i < 8; i++)
          if (mem_wmask[d][i]) mem[mem_waddr[d][6:3]][8*i +: 8] = mem_wdata[d][8*i +: 8];
      end else begin
        n_checks++;
        if (mem_wmask[d] !== 8'h00) begin
          n_errors++;
          $display("FAIL %s mask_idle: got 0x%02h expected 0x00", tag, mem_wmask[d]);
        end
      end
      if (resp_valid[d]) begin
        seen = 1'b1;
        break;
      end
      check({tag, " req_ready busy"}, 64'(req_ready[d]), 64'd0);
    end
    check({tag, " resp_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(k), e.misalign ? 64'd1 : 64'(lat + 1));
    check({tag, " wen_pulses"}, 64'(pulses), (wen && !e.misalign) ? 64'd1 : 64'd0);
    if (e.misalign) check({tag, " raddr_kept"}, mem_raddr[d], raddr0);

    held = resp_rdata[d];
    repeat (hold) begin
      @(negedge clk);
      check({tag, " hold valid"}, 64'(resp_valid[d]), 64'd1);
      check({tag, " hold rdata"}, resp_rdata[d], held);
      check({tag, " hold req_ready"}, 64'(req_ready[d]), 64'd0);
    end

    got = sb.pop_front();
    check({tag, " resp_rdata"}, resp_rdata[d], got.rdata);
    check({tag, " resp_misalign"}, 64'(resp_misalign[d]), 64'(got.misalign));
    check({tag, " req_ready resp"}, 64'(req_ready[d]), 64'd0);

    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check({tag, " resp_valid drop"}, 64'(resp_valid[d]), 64'd0);
    check({tag, " misalign clear"}, 64'(resp_misalign[d]), 64'd0);
    check({tag, " req_ready after"}, 64'(req_ready[d]), 64'd1);
  endtask

  // Store on the LATENCY=4 unit, then reset mid-BUSY: nothing may be written.
  task automatic reset_mid_busy(input logic [63:0] addr);
    @(negedge clk);
    req_addr[1] = addr; req_wdata[1] = 64'hCAFE_F00D_CAFE_F00D; req_wen[1] = 1'b1;
    req_size[1] = 2'd3; req_unsigned[1] = 1'b0; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("rst busy req_ready", 64'(req_ready[1]), 64'd0);
    check("rst busy mem_wen", 64'(mem_wen[1]), 64'd0);
    #2 rst_n[1] = 1'b0;
    #1 check_reset_outputs(1, "rst mid");
    repeat (3) begin
      @(negedge clk);
      check("rst held mem_wen", 64'(mem_wen[1]), 64'd0);
    end
    rst_n[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst after mem_wen", 64'(mem_wen[1]), 64'd0);
      check("rst after req_ready", 64'(req_ready[1]), 64'd1);
      check("rst after resp_valid", 64'(resp_valid[1]), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    mem[4] = 64'h0000_0000_F000_8000;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = 64'd0; req_wdata[d] = 64'd0;
      req_wen[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0; resp_ready[d] = 1'b0;
    end
    #12;
    check_reset_outputs(0, "reset lat1");
    check_reset_outputs(1, "reset lat4");
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // LATENCY=1 unit.
    do_access(0, "st_dword",  64'h8000_0010, 64'h1122_3344_5566_7788, 1'b1, 2'd3, 1'b0, 0);
    do_access(0, "st_byte",   64'h8000_0013, 64'h0000_0000_0000_00AB, 1'b1, 2'd0, 1'b0, 0);
    do_access(0, "ld_dword",  64'h8000_0010, 64'd0, 1'b0, 2'd3, 1'b0, 0);
    do_access(0, "ld_half_s", 64'h8000_0020, 64'd0, 1'b0, 2'd1, 1'b0, 0);
    do_access(0, "ld_half_u", 64'h8000_0020, 64'd0, 1'b0, 2'd1, 1'b1, 0);
    do_access(0, "ld_word_s", 64'h8000_0024, 64'd0, 1'b0, 2'd2, 1'b0, 0);
    do_access(0, "ld_byte_s", 64'h8000_0013, 64'd0, 1'b0, 2'd0, 1'b0, 1);
    do_access(0, "ld_mis",    64'h8000_0002, 64'd0, 1'b0, 2'd2, 1'b0, 0);
    do_access(0, "st_mis",    64'h8000_0011, 64'hFFFF, 1'b1, 2'd1, 1'b0, 2);
    do_access(0, "st_half_h", 64'h8000_0036, 64'h1234_BEEF, 1'b1, 2'd1, 1'b0, 0);
    do_access(0, "ld_word_h", 64'h8000_0034, 64'd0, 1'b0, 2'd2, 1'b1, 0);

    // LATENCY=4 unit, including a slow consumer.
    do_access(1, "l4_ld_half", 64'h8000_0020, 64'd0, 1'b0, 2'd1, 1'b0, 5);
    do_access(1, "l4_st_word", 64'h8000_0024, 64'h0000_0000_DEAD_BEEF, 1'b1, 2'd2, 1'b0, 0);
    do_access(1, "l4_ld_wu",   64'h8000_0024, 64'd0, 1'b0, 2'd2, 1'b1, 0);
    do_access(1, "l4_ld_ws",   64'h8000_0024, 64'd0, 1'b0, 2'd2, 1'b0, 3);
    do_access(1, "l4_ld_mis",  64'h8000_0021, 64'd0, 1'b0, 2'd3, 1'b0, 0);

    reset_mid_busy(64'h8000_0028);
    do_access(1, "l4_ld_after_rst", 64'h8000_0028, 64'd0, 1'b0, 2'd3, 1'b0, 0);
    check("post_rst mem word", mem[5], 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_core.md
Name: lsu_core

Overview:
- Load/store unit directly upstream of the DPI-backed data memory block.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts each request into an aligned 64-bit memory access with the correct byte mask and shifted write data.
- Models a configurable memory latency, then returns load data, sign- or zero-extended, on a valid/ready response channel.

Parameters:
LATENCY, 1, cycles spent in BUSY per access; legal range 1..15.
RESET_ADDR, 64'h0000_0000_8000_0000, value of mem_raddr/mem_waddr at reset (pmem base); keeps DPI reads in range.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_addr  input  64  byte address.
req_wdata  input  64  store data, right-aligned.
req_wen  input  1  1 = store, 0 = load.
req_size  input  2  0 byte, 1 half, 2 word, 3 dword.
req_unsigned  input  1  load zero-extends when 1.
resp_valid  output  1  response available.
resp_ready  input  1  consumer accepts response.
resp_rdata  output  64  extended load data; 0 for stores and misaligned accesses.
resp_misalign  output  1  request was misaligned; no memory access performed.
mem_raddr  output  64  aligned read address to memory.
mem_waddr  output  64  aligned write address to memory.
mem_wdata  output  64  lane-shifted write data.
mem_wmask  output  8  byte-lane write mask.
mem_wen  output  1  write strobe, one-cycle pulse.
mem_rdata  input  64  combinational read data from memory.

Behaviour:
- States: IDLE, BUSY, RESP. Reset state is IDLE.
- Output values during reset:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_misalign=0.
  - mem_raddr=mem_waddr=RESET_ADDR, mem_wdata=0, mem_wmask=0, mem_wen=0.
  - Latency counter=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, wen, size, unsigned.
  - Offset o=req_addr[2:0]. Misaligned if addr mod (1<<size) != 0.
  - Aligned request: latch {addr[63:3],3'b000} into mem_raddr and mem_waddr, load counter with LATENCY-1, go to BUSY.
  - Misaligned request: go to RESP with resp_misalign=1 and resp_rdata=0. mem_* registers are not updated.
- BUSY:
  - req_ready=0. mem_raddr/mem_waddr hold the latched aligned address.
  - Counter decrements each cycle.
  - In the cycle where counter==0:
    - If store: mem_wen=1 for exactly this cycle.
    - If load: capture mem_rdata.
    - Next state is RESP.
  - mem_wen=0 in every other cycle and state.
- Write mask (combinational from latched size/o):
  - byte: 8'h01<<o
  - half: 8'h03<<o
  - word: 8'h0F<<o
  - dword: 8'hFF
  - mem_wmask is nonzero only while mem_wen=1; otherwise 0.
- mem_wdata = latched wdata << (8*o); bits shifted out are dropped.
- Load extraction at capture:
  - s = mem_rdata >> (8*o); take the low 8/16/32/64 bits of s per size.
  - unsigned=1: zero-extend. unsigned=0: sign-extend from the top bit of the field.
  - dword ignores req_unsigned.
  - Result registered into resp_rdata. Stores return resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_misalign held stable until resp_ready.
  - On resp_ready: go to IDLE; resp_valid deasserts next cycle and resp_misalign clears.
  - No new request is accepted in the same cycle as the response handshake (req_ready=0 in RESP).
- Throughput: minimum 1+LATENCY+1 cycles per access with resp_ready tied high.
- Asynchronous reset at any point, including mid-BUSY, returns all state and outputs to reset values immediately. A pending store whose wen cycle has not yet occurred is never written.
- req_* inputs are ignored outside IDLE.

Test Plan:
1. LATENCY=1, store dword addr 0x80000010, wdata 0x1122334455667788 -> mem_wen high exactly 1 cycle, mem_waddr 0x80000010, mem_wmask 0xFF, mem_wdata 0x1122334455667788, resp_rdata 0.
2. Store byte addr 0x80000013, wdata 0xAB -> mem_waddr 0x80000010, mem_wmask 0x08, mem_wdata 0x00000000AB000000.
3. mem_rdata model returns 0x00000000F0008000 at 0x80000020:
   - Load half signed addr 0x80000020 -> resp_rdata 0xFFFFFFFFFFFF8000.
   - Same load, unsigned -> 0x0000000000008000.
   - Load word signed addr 0x80000024 -> 0x0000000000000000.
4. Load word addr 0x80000002 -> resp_misalign=1, resp_rdata 0, no mem_wen, mem_raddr unchanged, resp_valid one cycle after acceptance.
5. LATENCY=4, resp_ready held low for 5 cycles:
   - resp_valid asserts 5 cycles after acceptance.
   - resp_valid and resp_rdata hold stable while resp_ready is low.
   - req_ready=0 until the cycle after the handshake.
6. Store accepted, rst_n pulsed low during BUSY (LATENCY=4) -> outputs immediately at reset values, mem_wen never asserted, req_ready=1 after release.
